// File: rtl/reset_seq_ctrl_pkg.sv
// Shared types and helpers for the reset sequencer.
// Holds the FSM state encoding and the request length rule.
package reset_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    SETTLE = 2'd1,
    IDLE   = 2'd2
  } reset_seq_state_e;

  function automatic logic [31:0] eff_len(
    input logic [31:0] req_cycles,
    input logic [31:0] min_cycles
  );
    return (req_cycles < min_cycles) ? min_cycles : req_cycles;
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable down-counter for the reset sequencer.
// expire is high while the count equals one.
module reset_seq_timer #(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: drives gen_reset/gen_reset_n with a minimum
// width, a settle window, and handshaked software requests.
module reset_seq_ctrl
  import reset_seq_ctrl_pkg::*;
#(
  parameter int MIN_CYCLES  = 8,
  parameter int POST_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_cycles,
  output logic             req_ready,
  output logic             gen_reset,
  output logic             gen_reset_n,
  output logic             ready,
  output logic             req_done
);

  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_CYCLES);
  localparam logic [CNT_W-1:0] POST_V = CNT_W'(POST_CYCLES);

  reset_seq_state_e state_q, state_d;
  logic origin_q, origin_d;
  logic arm_q, arm_d;
  logic gen_reset_q, gen_reset_d;
  logic gen_reset_n_q;
  logic ready_q, ready_d;
  logic req_ready_q;
  logic req_done_q, req_done_d;
  logic load;
  logic [CNT_W-1:0] load_val;
  logic expire;

  reset_seq_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (MIN_V)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .value   (load_val),
    .expire  (expire)
  );

  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    arm_d    = 1'b0;
    load     = 1'b0;
    load_val = MIN_V;
    unique case (state_q)
      ASSERT: begin
        // Reload on the release edge so power-on spans MIN_CYCLES edges
        if (arm_q) begin
          load     = 1'b1;
          load_val = MIN_V;
        end else if (expire) begin
          if (POST_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = SETTLE;
            load     = 1'b1;
            load_val = POST_V;
          end
        end
      end
      SETTLE: begin
        if (expire) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d  = ASSERT;
          load     = 1'b1;
          load_val = CNT_W'(eff_len(32'(req_cycles), 32'(MIN_CYCLES)));
          origin_d = 1'b1;
        end
      end
      default: begin
        state_d = ASSERT;
      end
    endcase
    req_done_d  = (state_d == IDLE) && (state_q != IDLE) && origin_q;
    if (req_done_d) begin
      origin_d = 1'b0;
    end
    gen_reset_d = (state_d == ASSERT);
    ready_d     = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ASSERT;
      origin_q      <= 1'b0;
      arm_q         <= 1'b1;
      gen_reset_q   <= 1'b1;
      gen_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      req_ready_q   <= 1'b0;
      req_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      origin_q      <= origin_d;
      arm_q         <= arm_d;
      gen_reset_q   <= gen_reset_d;
      gen_reset_n_q <= ~gen_reset_d;
      ready_q       <= ready_d;
      req_ready_q   <= ready_d;
      req_done_q    <= req_done_d;
    end
  end

  assign gen_reset   = gen_reset_q;
  assign gen_reset_n = gen_reset_n_q;
  assign ready       = ready_q;
  assign req_ready   = req_ready_q;
  assign req_done    = req_done_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl: default instance plus a
// POST_CYCLES=0, 8-bit instance for the zero-settle and max-length cases.
module tb_reset_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn, rv;
  logic [15:0] rc;
  logic        rr, gr, grn, rdy, done;

  logic        rn_b, rv_b;
  logic [7:0]  rc_b;
  logic        rr_b, gr_b, grn_b, rdy_b, done_b;

  int checks = 0;
  int errors = 0;

  reset_seq_ctrl #(
    .MIN_CYCLES  (8),
    .POST_CYCLES (4),
    .CNT_W       (16)
  ) dut_a (
    .clk         (clk),
    .reset_n     (rn),
    .req_valid   (rv),
    .req_cycles  (rc),
    .req_ready   (rr),
    .gen_reset   (gr),
    .gen_reset_n (grn),
    .ready       (rdy),
    .req_done    (done)
  );

  reset_seq_ctrl #(
    .MIN_CYCLES  (8),
    .POST_CYCLES (0),
    .CNT_W       (8)
  ) dut_b (
    .clk         (clk),
    .reset_n     (rn_b),
    .req_valid   (rv_b),
    .req_cycles  (rc_b),
    .req_ready   (rr_b),
    .gen_reset   (gr_b),
    .gen_reset_n (grn_b),
    .ready       (rdy_b),
    .req_done    (done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input bit b, input string tag);
    chk({tag, ".gr"},   32'(b ? gr_b  : gr),   32'd1);
    chk({tag, ".grn"},  32'(b ? grn_b : grn),  32'd0);
    chk({tag, ".rr"},   32'(b ? rr_b  : rr),   32'd0);
    chk({tag, ".rdy"},  32'(b ? rdy_b : rdy),  32'd0);
    chk({tag, ".done"}, 32'(b ? done_b : done), 32'd0);
  endtask

  // Steps edge 0 .. eff+post; edge 0 is the release or handshake edge.
  task automatic seq(input bit b, input string tag, input int eff,
                     input int post, input bit exp_done, input bit drop);
    for (int k = 0; k <= eff + post; k++) begin
      tick();
      if (drop && k == 0) begin
        if (b) rv_b = 1'b0;
        else   rv = 1'b0;
      end
      chk($sformatf("%s.gr@%0d", tag, k),
          32'(b ? gr_b : gr), 32'(k < eff));
      chk($sformatf("%s.grn@%0d", tag, k),
          32'(b ? grn_b : grn), 32'(k >= eff));
      chk($sformatf("%s.rdy@%0d", tag, k),
          32'(b ? rdy_b : rdy), 32'(k >= eff + post));
      chk($sformatf("%s.rr@%0d", tag, k),
          32'(b ? rr_b : rr), 32'(k >= eff + post));
      chk($sformatf("%s.done@%0d", tag, k),
          32'(b ? done_b : done), 32'(exp_done && k == eff + post));
    end
  endtask

  initial begin
    rn = 1'b0; rv = 1'b0; rc = '0;
    rn_b = 1'b0; rv_b = 1'b0; rc_b = '0;

    // Power-on: 5 reset cycles then release
    repeat (5) tick();
    chk_rst(1'b0, "rst_a");
    chk_rst(1'b1, "rst_b");
    @(negedge clk);
    rn = 1'b1;
    seq(1'b0, "por", 8, 4, 1'b0, 1'b0);

    // Long request
    rv = 1'b1; rc = 16'd20;
    seq(1'b0, "req20", 20, 4, 1'b1, 1'b1);

    // Short and zero requests, back-to-back from the first IDLE cycle
    rv = 1'b1; rc = 16'd3;
    seq(1'b0, "req3", 8, 4, 1'b1, 1'b1);
    rv = 1'b1; rc = 16'd0;
    seq(1'b0, "req0", 8, 4, 1'b1, 1'b1);

    // Backpressure: valid held high throughout
    rv = 1'b1; rc = 16'd10;
    seq(1'b0, "bp1", 10, 4, 1'b1, 1'b0);
    seq(1'b0, "bp2", 10, 4, 1'b1, 1'b0);
    rv = 1'b0;

    // Reset in cycle 5 of a 20-cycle request, valid asserted during reset
    rv = 1'b1; rc = 16'd20;
    tick();
    rv = 1'b0;
    chk("mid.gr0", 32'(gr), 32'd1);
    repeat (4) tick();
    rn = 1'b0; rv = 1'b1;
    tick();
    chk_rst(1'b0, "mid_rst");
    tick();
    chk_rst(1'b0, "mid_rst2");
    rn = 1'b1; rv = 1'b0;
    seq(1'b0, "por2", 8, 4, 1'b0, 1'b0);
    tick();
    chk("post_por2.rdy", 32'(rdy), 32'd1);
    chk("post_por2.done", 32'(done), 32'd0);

    // POST_CYCLES=0 instance: power-on, req 9, then max length 255
    rn_b = 1'b1;
    seq(1'b1, "b_por", 8, 0, 1'b0, 1'b0);
    rv_b = 1'b1; rc_b = 8'd9;
    seq(1'b1, "b_req9", 9, 0, 1'b1, 1'b1);
    rv_b = 1'b1; rc_b = 8'hff;
    seq(1'b1, "b_max", 255, 0, 1'b1, 1'b1);
    tick();
    chk("b_end.done", 32'(done_b), 32'd0);
    chk("b_end.rdy", 32'(rdy_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
